// File: rtl/muldiv_iter_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// The pipeline drives through the master modport and the unit uses the slave modport.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       Md_op;
  logic             Start;
  logic             Flush;
  logic [WIDTH-1:0] Rs_in;
  logic [WIDTH-1:0] Rt_in;
  logic [WIDTH-1:0] Res_out;
  logic             Busy;
  logic             Done;
  logic             Md_stall;

  modport master (
    output Md_op, Start, Flush, Rs_in, Rt_in,
    input  Res_out, Busy, Done, Md_stall
  );

  modport slave (
    input  Md_op, Start, Flush, Rs_in, Rt_in,
    output Res_out, Busy, Done, Md_stall
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative EX-stage multiply/divide unit that owns the architectural Hi/Lo registers.
// Define MULDIV_EARLY_OUT_EN to finish trivial divides (|Rt|==0 or |Rs|<|Rt|) in a single cycle.
module muldiv_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  muldiv_iter_if.slave md
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_DIV   = 4'd1,
    OP_DIVU  = 4'd2,
    OP_MFHI  = 4'd3,
    OP_MFLO  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MUL   = 4'd7,
    OP_MULT  = 4'd8,
    OP_MULTU = 4'd9
  } op_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, rem_r;
  logic [WIDTH-1:0]   hi_r, lo_r, res_r;
  logic               q_neg, r_neg, dz, done_r;

  logic               is_mul, is_div, early_out;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic               mul_sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fin, quo_fin;

  always_comb begin
    is_mul = (md.Md_op == OP_MUL) || (md.Md_op == OP_MULT) || (md.Md_op == OP_MULTU);
    is_div = (md.Md_op == OP_DIV) || (md.Md_op == OP_DIVU);
    rs_neg = (md.Md_op == OP_DIV) && md.Rs_in[WIDTH-1];
    rt_neg = (md.Md_op == OP_DIV) && md.Rt_in[WIDTH-1];
    rs_abs = rs_neg ? -md.Rs_in : md.Rs_in;
    rt_abs = rt_neg ? -md.Rt_in : md.Rt_in;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (rt_abs == '0) || (rs_abs < rt_abs);
`else
  assign early_out = 1'b0;
`endif

  // One shared 2W-bit multiplier; signedness comes from sign-extending the latched operands.
  always_comb begin
    mul_sgn = (op_r != OP_MULTU);
    a_ext   = {{WIDTH{mul_sgn & a_r[WIDTH-1]}}, a_r};
    b_ext   = {{WIDTH{mul_sgn & b_r[WIDTH-1]}}, b_r};
    product = a_ext * b_ext;
  end

  // Restoring step: a_r shifts dividend bits out at the top and quotient bits in at the bottom.
  always_comb begin
    div_shift = {rem_r, a_r[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_r};
    div_ge    = ~div_diff[WIDTH];
    rem_nx    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_nx    = {a_r[WIDTH-2:0], div_ge};
    rem_fin   = r_neg ? -rem_nx : rem_nx;
    quo_fin   = q_neg ? -quo_nx : quo_nx;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_r   <= OP_NOP;
      a_r    <= '0;
      b_r    <= '0;
      rem_r  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      res_r  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (md.Flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (md.Start) begin
              if (md.Md_op == OP_MTHI) begin
                hi_r <= md.Rs_in;
              end else if (md.Md_op == OP_MTLO) begin
                lo_r <= md.Rs_in;
              end else if (is_mul) begin
                state <= S_MUL;
                op_r  <= md.Md_op;
                a_r   <= md.Rs_in;
                b_r   <= md.Rt_in;
                cnt   <= CNT_W'(MUL_LAT - 1);
              end else if (is_div && early_out) begin
                state  <= S_FIN;
                done_r <= 1'b1;
                hi_r   <= md.Rs_in;
                lo_r   <= (rt_abs == '0) ? '1 : '0;
              end else if (is_div) begin
                state <= S_DIV;
                op_r  <= md.Md_op;
                a_r   <= rs_abs;
                b_r   <= rt_abs;
                rem_r <= '0;
                q_neg <= rs_neg ^ rt_neg;
                r_neg <= rs_neg;
                dz    <= (md.Rt_in == '0);
                cnt   <= CNT_W'(WIDTH - 1);
              end
            end
          end
          S_MUL: begin
            if (cnt == '0) begin
              state  <= S_FIN;
              done_r <= 1'b1;
              if (op_r == OP_MUL) begin
                res_r <= product[WIDTH-1:0];
              end else begin
                hi_r <= product[2*WIDTH-1:WIDTH];
                lo_r <= product[WIDTH-1:0];
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_DIV: begin
            rem_r <= rem_nx;
            a_r   <= quo_nx;
            if (cnt == '0) begin
              state  <= S_FIN;
              done_r <= 1'b1;
              // Sign-corrected remainder of a zero divisor is Rs itself.
              hi_r   <= rem_fin;
              lo_r   <= dz ? '1 : quo_fin;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_FIN:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (md.Md_op)
      OP_MFHI: md.Res_out = hi_r;
      OP_MFLO: md.Res_out = lo_r;
      OP_MUL:  md.Res_out = res_r;
      default: md.Res_out = '0;
    endcase
  end

  assign md.Busy     = (state != S_IDLE);
  assign md.Done     = done_r;
  assign md.Md_stall = md.Busy | (md.Start & (is_mul | is_div));

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: a scoreboard queue holds the expected Hi/Lo and latency per op.
// Expected latencies follow MULDIV_EARLY_OUT_EN when it is defined for the build.
module tb_muldiv_iter;

  localparam int W  = 32;
  localparam int ML = 2;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MFHI  = 4'd3;
  localparam logic [3:0] OP_MFLO  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  muldiv_iter_if #(.WIDTH(W)) md ();

  muldiv_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .md    (md)
  );

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [63:0] hilo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint sa, sb_;
    sa  = longint'($signed(rs));
    sb_ = longint'($signed(rt));
    case (op)
      OP_DIV: begin
        if (rt == 32'h0) return {rs, 32'hFFFF_FFFF};
        if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb_), 32'(sa / sb_)};
      end
      OP_DIVU: begin
        if (rt == 32'h0) return {rs, 32'hFFFF_FFFF};
        return {rs % rt, rs / rt};
      end
      OP_MUL, OP_MULT: return 64'(sa * sb_);
      OP_MULTU:        return {32'h0, rs} * {32'h0, rt};
      default:         return 64'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    if (op == OP_MUL || op == OP_MULT || op == OP_MULTU) return ML;
`ifdef MULDIV_EARLY_OUT_EN
    begin
      logic [31:0] ma, mb;
      ma = (op == OP_DIV && rs[31]) ? -rs : rs;
      mb = (op == OP_DIV && rt[31]) ? -rt : rt;
      if (mb == 32'h0 || ma < mb) return 0;
    end
`endif
    return W;
  endfunction

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic read_hilo(input string tag, input logic [63:0] exp);
    logic [31:0] h;
    md.Md_op = OP_MFHI; #1 h = md.Res_out;
    md.Md_op = OP_MFLO; #1 check(tag, {h, md.Res_out}, exp);
    md.Md_op = OP_NOP;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] val);
    md.Md_op = op; md.Rs_in = val; md.Start = 1'b1;
    @(posedge Clk); #1;
    md.Start = 1'b0; md.Md_op = OP_NOP;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    md.Md_op = op; md.Rs_in = rs; md.Rt_in = rt; md.Start = 1'b1;
    @(posedge Clk); #1;
    md.Start = 1'b0; md.Md_op = OP_NOP;
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge Clk); #1;
      if (md.Done) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input string tag);
    exp_t e, got;
    int   lat = 0;
    e.tag = tag; e.op = op; e.hilo = model(op, rs, rt); e.lat = exp_lat(op, rs, rt);
    sb.push_back(e);
    md.Md_op = op; md.Rs_in = rs; md.Rt_in = rt; md.Start = 1'b1;
    #1 check({tag, "_stall_req"}, md.Md_stall, 1);
    @(posedge Clk); #1;
    md.Start = 1'b0; md.Md_op = OP_NOP;
    while (!md.Done && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    got = sb.pop_front();
    check({got.tag, "_lat"}, lat, got.lat);
    if (got.op == OP_MUL) begin
      md.Md_op = OP_MUL;
      #1 check({got.tag, "_res"}, md.Res_out, got.hilo[31:0]);
      md.Md_op = OP_NOP;
    end else begin
      read_hilo({got.tag, "_hilo"}, got.hilo);
    end
    check({got.tag, "_busy_fin"}, md.Busy, 1);
    @(posedge Clk); #1;
    check({got.tag, "_done_drop"}, md.Done, 0);
    check({got.tag, "_stall_rel"}, md.Md_stall, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    logic [3:0]  rop;
    int          lat;

    Rst_n = 1'b0;
    md.Md_op = OP_NOP; md.Start = 1'b0; md.Flush = 1'b0;
    md.Rs_in = '0; md.Rt_in = '0;
    #12;
    check("rst_busy", md.Busy, 0);
    check("rst_done", md.Done, 0);
    check("rst_stall", md.Md_stall, 0);
    read_hilo("rst_hilo", 64'h0);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Reset in the middle of a divide discards it and clears preloaded Hi/Lo.
    move_to(OP_MTHI, 32'h1234);
    move_to(OP_MTLO, 32'h5678);
    read_hilo("mt_preload", {32'h1234, 32'h5678});
    check("mt_idle", md.Busy, 0);
    launch(OP_DIV, 32'd1000, 32'd3);
    repeat (9) begin @(posedge Clk); #1; end
    check("div_busy_mid", md.Busy, 1);
    Rst_n = 1'b0;
    #1;
    check("midrst_busy", md.Busy, 0);
    check("midrst_done", md.Done, 0);
    read_hilo("midrst_hilo", 64'h0);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
    watch_no_done("midrst_no_done", 40);

    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_ff_2");

    // MUL leaves Hi/Lo alone; a Start arriving while busy is ignored.
    move_to(OP_MTHI, 32'hAA);
    move_to(OP_MTLO, 32'hBB);
    run_op(OP_MUL, 32'd3, 32'd5, "mul_3_5");
    read_hilo("mul_hilo_kept", {32'hAA, 32'hBB});
    launch(OP_MUL, 32'd7, 32'd9);
    md.Md_op = OP_MTHI; md.Rs_in = 32'hDEAD; md.Start = 1'b1;
    @(posedge Clk); #1;
    md.Start = 1'b0; md.Md_op = OP_NOP;
    lat = 1;
    while (!md.Done && lat < 100) begin @(posedge Clk); #1; lat++; end
    check("busy_start_lat", lat, ML);
    md.Md_op = OP_MUL;
    #1 check("mul_7_9_res", md.Res_out, 32'd63);
    read_hilo("busy_start_ignored", {32'hAA, 32'hBB});
    @(posedge Clk); #1;

    run_op(OP_DIVU, 32'd5, 32'd0, "divu_5_0");
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, "div_neg_0");

    // Flush mid-divide returns to IDLE with no commit.
    move_to(OP_MTHI, 32'h55);
    move_to(OP_MTLO, 32'h66);
    launch(OP_DIV, 32'd1000, 32'd3);
    repeat (4) begin @(posedge Clk); #1; end
    md.Flush = 1'b1;
    @(posedge Clk); #1;
    md.Flush = 1'b0;
    check("flush_busy", md.Busy, 0);
    watch_no_done("flush_no_done", 40);
    read_hilo("flush_hilo_kept", {32'h55, 32'h66});

    // Flush beats Start in the same IDLE cycle.
    md.Md_op = OP_MTHI; md.Rs_in = 32'h77; md.Start = 1'b1; md.Flush = 1'b1;
    @(posedge Clk); #1;
    md.Start = 1'b0; md.Flush = 1'b0; md.Md_op = OP_NOP;
    read_hilo("flush_start_drop", {32'h55, 32'h66});

    md.Md_op = OP_MFHI; md.Start = 1'b1;
    #1 check("mfhi_no_stall", md.Md_stall, 0);
    md.Start = 1'b0; md.Md_op = OP_NOP;

    for (int i = 0; i < 6; i++) begin
      r1  = $urandom;
      r2  = (i == 2) ? 32'h1 : $urandom >> (i * 4);
      rop = (i % 4 == 0) ? OP_DIV : (i % 4 == 1) ? OP_DIVU : (i % 4 == 2) ? OP_MULT : OP_MULTU;
      run_op(rop, r1, r2, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised, posedge-clocked successor to the pipeline CPU's multiply/divide unit.
- Executes DIV/DIVU/MUL/MULT/MULTU/MFHI/MFLO/MTHI/MTLO for a WIDTH-bit datapath using an explicit Start/Done handshake.
- Multiply uses a MUL_LAT-stage latency counter; divide is a 1-bit-per-cycle restoring divider.
- Sits in EX stage; drives the pipeline stall and owns the architectural Hi/Lo.

Parameters:
- WIDTH, 32, operand/Hi/Lo width (even, >=8)
- MUL_LAT, 2, cycles spent in MUL state before result commit (>=1)

Ports:
- Clk  input  1  clock, all state on rising edge
- Rst_n  input  1  asynchronous active-low reset
- Md_op  input  4  operation code (codes below)
- Start  input  1  op valid this cycle; sampled only in IDLE
- Flush  input  1  synchronous abort of in-flight op
- Rs_in  input  WIDTH  operand A / MTHI-MTLO source
- Rt_in  input  WIDTH  operand B
- Res_out  output  WIDTH  MUL low result, or Hi/Lo for MFHI/MFLO
- Busy  output  1  state != IDLE
- Done  output  1  one-cycle pulse when MUL/MULT/MULTU/DIV/DIVU commits
- Md_stall  output  1  Busy | (Start & Md_op is mul/div class)

Behaviour:
- Codes: 0001 DIV, 0010 DIVU, 0011 MFHI, 0100 MFLO, 0101 MTHI, 0110 MTLO, 0111 MUL, 1000 MULT, 1001 MULTU; others NOP.
- Reset (async, Rst_n=0): state IDLE, Hi=Lo=0, Res reg=0, counter=0, Busy=0, Done=0; Res_out=0. Reset mid-operation discards the op, no Done.
- States: IDLE, MUL, DIV, FIN.
- IDLE + Start: MTHI/MTLO write Hi/Lo from Rs_in at that edge, stay IDLE, no Done. MUL-class -> MUL, latch operands, cnt=MUL_LAT-1. DIV-class -> DIV, latch |Rs|,|Rt| (signed only for DIV), record sign of quotient (Rs^Rt) and remainder (Rs), cnt=WIDTH-1. MFHI/MFLO/NOP: no state change.
- Start while Busy: ignored (pipeline is stalled by Md_stall).
- MUL: decrement cnt; at cnt==0 -> FIN. Product computed full 2*WIDTH (signed for MUL/MULT, unsigned MULTU).
- DIV: one restoring step per cycle (shift remainder left, bring in next dividend bit, subtract divisor if non-negative, set quotient bit); at cnt==0 -> FIN.
- FIN (one cycle): sign-correct; MULT/MULTU/DIV/DIVU write {Hi,Lo} (Hi=remainder, Lo=quotient for divide); MUL writes only Res reg, Hi/Lo untouched; Done=1; -> IDLE.
- Latency from Start edge t: Done high in cycle t+MUL_LAT+1 (mul) / t+WIDTH+1 (div); results readable same cycle as Done.
- Divide by zero: Lo=all ones, Hi=Rs_in (unmodified). Signed overflow (min / -1): Lo=min, Hi=0. Neither raises an exception.
- Res_out: MFHI -> Hi, MFLO -> Lo, MUL -> Res reg, else 0; combinational from registers.
- Flush: at next edge state -> IDLE, Hi/Lo/Res unchanged, no Done. Flush and Start in the same IDLE cycle: Flush wins, op dropped. Flush in FIN cycle: commit still happens (FIN is atomic).
- Md_stall falls in the FIN cycle's following cycle, i.e., pipeline releases the cycle after Done.

Optional Feature:
- MULDIV_EARLY_OUT_EN: when defined, DIV entry checks |Rt|==0 or |Rs|<|Rt|; if true go directly to FIN (Done at t+1) with div-by-zero or quotient 0/remainder Rs result. When undefined, all divides take fixed WIDTH+1 cycles.

Test Plan:
- Reset mid-DIV at cycle 10 -> Busy=0, Hi=Lo=0, no Done; next DIVU 100/7 -> Lo=14, Hi=2, Done at t+33 (WIDTH=32).
- DIV Rs=0xFFFFFFF9 (-7), Rt=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MULT 0xFFFFFFFF*2 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; MULTU same -> Hi=1, Lo=0xFFFFFFFE; Done at t+3 (MUL_LAT=2).
- MUL 3*5 with Hi=0xAA,Lo=0xBB preloaded via MTHI/MTLO -> Res_out=15, Hi/Lo unchanged; MFHI -> 0xAA.
- DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=5; with MULDIV_EARLY_OUT_EN Done at t+1, without at t+33.
- Flush at cycle 5 of DIV -> IDLE next edge, no Done, Hi/Lo keep prior values; Start during Busy ignored.
